// File: rtl/linear_layer_start_fifo.sv
// Start-token FIFO: shift-register storage, occupancy counter and registered flags.
// Optional occupancy output port is enabled by defining START_FIFO_COUNT_EN.
module linear_layer_start_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
`ifdef START_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`endif
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  full_n_q, empty_n_q;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read  & if_read_ce  & empty_n_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Control state: counter and flags, registered from the next-state count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= CNT_ZERO;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      empty_n_q <= (cnt_d != CNT_ZERO);
      full_n_q  <= (cnt_d != CNT_FULL);
    end
  end

  // Storage is data only: it shifts on every accepted write and is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_q[i] <= mem_q[i-1];
      end
      mem_q[0] <= if_din;
    end
  end

  // Oldest entry sits at cnt-1; clamp the empty case to keep the index in range.
  always_comb begin
    rd_addr = '0;
    if (cnt_q != CNT_ZERO) begin
      rd_addr = ADDR_WIDTH'(cnt_q - CNT_ONE);
    end
  end

  assign if_dout    = mem_q[rd_addr];
  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;

`ifdef START_FIFO_COUNT_EN
  assign if_num_data_valid = cnt_q;
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo.sv
// Scoreboard bench for linear_layer_start_fifo (DEPTH=5, DATA_WIDTH=1).
module tb_linear_layer_start_fifo;
  localparam int DATA_WIDTH = 1;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 5;

  logic clk = 1'b0;
  logic reset;
  logic if_full_n, if_empty_n;
  logic if_write_ce, if_write, if_read_ce, if_read;
  logic [DATA_WIDTH-1:0] if_din, if_dout;
`ifdef START_FIFO_COUNT_EN
  logic [ADDR_WIDTH:0] if_num_data_valid;
`endif

  int errors = 0;
  int checks = 0;
  int mcnt   = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  linear_layer_start_fifo #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .if_full_n(if_full_n), .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout)
`ifdef START_FIFO_COUNT_EN
    , .if_num_data_valid(if_num_data_valid)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; flags checked against the model before the edge.
  task automatic cycle(input logic w, input logic r, input logic [DATA_WIDTH-1:0] d,
                       input logic rst = 1'b0);
    logic do_push, do_pop;
    reset = rst; if_write = w; if_read = r; if_din = d;
    if_write_ce = 1'b1; if_read_ce = 1'b1;
    @(negedge clk);
    chk("empty_n", {31'b0, if_empty_n}, {31'b0, (mcnt != 0)});
    chk("full_n",  {31'b0, if_full_n},  {31'b0, (mcnt != DEPTH)});
`ifdef START_FIFO_COUNT_EN
    chk("count", {28'b0, if_num_data_valid}, mcnt);
`endif
    do_push = w && (mcnt != DEPTH);
    do_pop  = r && (mcnt != 0);
    @(posedge clk);
    if (rst) begin
      mcnt = 0;
      exp_q.delete();
    end else begin
      if (do_push) exp_q.push_back(d);
      if (do_push && !do_pop) mcnt++;
      if (do_pop && !do_push) mcnt--;
    end
    #1;
  endtask

  // Monitor: whenever a token is presented, compare it with the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && if_empty_n === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("dout_unexpected", 32'd1, 32'd0);
        end else begin
          chk("dout", {31'b0, if_dout}, {31'b0, exp_q[0]});
          if (if_read === 1'b1 && if_read_ce === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_WIDTH-1:0] fill1 [5];
    logic [DATA_WIDTH-1:0] fill2 [5];
    fill1 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    fill2 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; if_write = 0; if_read = 0; if_din = 0; if_write_ce = 0; if_read_ce = 0;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    // Idle after reset with random data and no writes
    for (int i = 0; i < 10; i++) cycle(0, 0, DATA_WIDTH'($urandom_range(0, 1)));
    // Fill, extra write ignored while full, then drain
    for (int i = 0; i < 5; i++) cycle(1, 0, fill1[i]);
    cycle(1, 0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    // Steady push+pop at occupancy 3
    cycle(1, 0, 1'b1); cycle(1, 0, 1'b0); cycle(1, 0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1, 1, DATA_WIDTH'(i % 2));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    // Full with write and read together: only the pop is taken
    for (int i = 0; i < 5; i++) cycle(1, 0, fill2[i]);
    cycle(1, 1, 1'b0);
    cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    // Empty with write and read together: only the push is taken
    cycle(1, 1, 1'b1);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    // Reset at occupancy 3 during a push, then only the new token comes out
    cycle(1, 0, 1'b1); cycle(1, 0, 1'b1); cycle(1, 0, 1'b0);
    cycle(1, 0, 1'b0, 1'b1);
    cycle(0, 0, 0);
    cycle(1, 0, 1'b1);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
